// File: rtl/seg7_pkg.sv
// Shared types, glyphs and decode for the multiplexed 7-segment driver.
// Glyphs are active-low {a,b,c,d,e,f,g}.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIG_DASH  = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;

  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] digit_glyph(
    input digit_t d
  );
    case (d)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      DIG_DASH: return GLYPH_DASH;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Field values, update request and display outputs of the driver.
// master = controller side, slave = display driver side.
interface seg7_if #(
  parameter int NUM_FIELDS       = 2,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int VAL_W            = 7
);

  localparam int ND = NUM_FIELDS * DIGITS_PER_FIELD;

  logic [NUM_FIELDS*VAL_W-1:0] values;
  logic                        upd;
  logic                        busy;
  logic [NUM_FIELDS-1:0]       blink_mask;
  logic [ND-1:0]               anode;
  logic [6:0]                  seg;

  modport master (
    output values, upd, blink_mask,
    input  busy, anode, seg
  );

  modport slave (
    input  values, upd, blink_mask,
    output busy, anode, seg
  );

endinterface

// File: rtl/seg7_mux_display_bin2bcd.sv
// Sequential double-dabble converter, one field at a time, atomic commit.
// SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros at commit.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS       = 2,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int VAL_W            = 7
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_FIELDS*VAL_W-1:0]            values,
  input  logic                                   upd,
  output logic                                   busy,
  output logic [NUM_FIELDS*DIGITS_PER_FIELD*4-1:0] disp
);

  localparam int BW = DIGITS_PER_FIELD * 4;
  localparam int SW = NUM_FIELDS * VAL_W;
  localparam int DW = NUM_FIELDS * BW;
  localparam int FW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int CW = VAL_W > 1 ? $clog2(VAL_W) : 1;
  localparam logic [31:0] MAXV =
    32'(10 ** DIGITS_PER_FIELD - 1);

  conv_state_t state, state_nx;

  logic                  pending;
  logic [SW-1:0]         shadow;
  logic [NUM_FIELDS-1:0] ovf;
  logic [BW-1:0]         acc, acc_add, acc_nx;
  logic [DW-1:0]         bcd_st, bcd_st_nx;
  logic [DW-1:0]         commit_codes;
  logic [FW-1:0]         fcnt;
  logic [CW-1:0]         bcnt;
  logic                  last_bit, last_field;

  function automatic logic [BW-1:0] add3(
    input logic [BW-1:0] b
  );
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS_PER_FIELD; i++)
      if (b[i*4 +: 4] >= 4'd5)
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  assign busy       = (state != IDLE);
  assign last_bit   = (bcnt == CW'(VAL_W - 1));
  assign last_field = (fcnt == FW'(NUM_FIELDS - 1));

  always_comb begin
    acc_add   = add3(acc);
    acc_nx    = {acc_add[BW-2:0], shadow[VAL_W-1]};
    bcd_st_nx = bcd_st >> BW;
    bcd_st_nx[DW-1 -: BW] = acc_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (upd) state_nx = CAPTURE;
      CAPTURE: state_nx = SHIFT;
      SHIFT:   if (last_bit && last_field)
                 state_nx = COMMIT;
      COMMIT:  state_nx = (pending || upd) ?
                          CAPTURE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      shadow  <= '0;
      ovf     <= '0;
      acc     <= '0;
      bcd_st  <= '0;
      fcnt    <= '0;
      bcnt    <= '0;
      disp    <= '0;
    end else begin
      if (state == COMMIT)  pending <= 1'b0;
      else if (upd && busy) pending <= 1'b1;
      unique case (state)
        CAPTURE: begin
          shadow <= values;
          for (int f = 0; f < NUM_FIELDS; f++)
            ovf[f] <= 32'(values[f*VAL_W +: VAL_W]) > MAXV;
          acc  <= '0;
          fcnt <= '0;
          bcnt <= '0;
        end
        SHIFT: begin
          // Low field of shadow is the one being converted.
          if (last_bit) begin
            acc    <= '0;
            bcd_st <= bcd_st_nx;
            shadow <= shadow >> VAL_W;
            bcnt   <= '0;
            fcnt   <= fcnt + 1'b1;
          end else begin
            acc    <= acc_nx;
            shadow[VAL_W-1:0] <=
              {shadow[VAL_W-2:0], 1'b0};
            bcnt   <= bcnt + 1'b1;
          end
        end
        COMMIT:  disp <= commit_codes;
        default: ;
      endcase
    end
  end

  always_comb begin : build_codes
    digit_t code;
    digit_t nib;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lead;
`endif
    commit_codes = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lead = 1'b1;
`endif
      for (int d = DIGITS_PER_FIELD - 1; d >= 0; d--) begin
        nib  = bcd_st[f*BW + d*4 +: 4];
        code = nib;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead = lead && (nib == 4'd0);
        if (lead && d != 0) code = DIG_BLANK;
`endif
        if (ovf[f]) code = DIG_DASH;
        commit_codes[(f*DIGITS_PER_FIELD + d)*4 +: 4] = code;
      end
    end
  end

endmodule

// File: rtl/seg7_mux_display.sv
// Multiplexed 7-segment driver: scan, blink and output registers.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN (handled in bin2bcd_seq).
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS       = 2,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int VAL_W            = 7,
  parameter int REFRESH_CYCLES   = 100000,
  parameter int BLINK_CYCLES     = 25000000
) (
  input logic  clk,
  input logic  rst,
  seg7_if.slave bus
);

  localparam int ND  = NUM_FIELDS * DIGITS_PER_FIELD;
  localparam int IW  = ND > 1 ? $clog2(ND) : 1;
  localparam int RW  =
    REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  localparam int BLW =
    BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;

  logic [ND*4-1:0] disp;
  logic [RW-1:0]   refresh;
  logic [IW-1:0]   idx;
  logic [BLW-1:0]  blink_cnt;
  logic            blink_phase;
  digit_t          cur_code;
  logic            cur_blink;

  bin2bcd_seq #(
    .NUM_FIELDS       (NUM_FIELDS),
    .DIGITS_PER_FIELD (DIGITS_PER_FIELD),
    .VAL_W            (VAL_W)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .values (bus.values),
    .upd    (bus.upd),
    .busy   (bus.busy),
    .disp   (disp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == RW'(REFRESH_CYCLES - 1)) begin
      refresh <= '0;
      idx     <= (idx == IW'(ND - 1)) ? '0 : idx + 1'b1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLW'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_blink = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = disp[i*4 +: 4];
        cur_blink = bus.blink_mask[i / DIGITS_PER_FIELD];
      end
    end
  end

  // Blinked digits keep their anode low so scan timing is unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.anode <= '1;
      bus.seg   <= GLYPH_BLANK;
    end else begin
      bus.anode <= ~(ND'(1) << idx);
      bus.seg   <= (blink_phase && cur_blink) ?
                   GLYPH_BLANK : digit_glyph(cur_code);
    end
  end

endmodule
